// File: rtl/keypad_pkg.sv
// keypad_pkg: shared FSM states, key code map and default parameters for keypad_scan_ctrl.
package keypad_pkg;
    typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESENT, RELEASE} state_t;
    localparam logic [3:0] KEY_0 = 4'd0;
    localparam logic [3:0] KEY_1 = 4'd1;
    localparam logic [3:0] KEY_2 = 4'd2;
    localparam logic [3:0] KEY_3 = 4'd3;
    localparam logic [3:0] KEY_4 = 4'd4;
    localparam logic [3:0] KEY_5 = 4'd5;
    localparam logic [3:0] KEY_6 = 4'd6;
    localparam logic [3:0] KEY_7 = 4'd7;
    localparam logic [3:0] KEY_8 = 4'd8;
    localparam logic [3:0] KEY_9 = 4'd9;
    localparam logic [3:0] KEY_START = 4'd10;
    localparam logic [3:0] KEY_STOP = 4'd11;
    localparam int DEF_NUM_COLS = 3;
    localparam int DEF_NUM_ROWS = 4;
    localparam int DEF_SCAN_DIV = 7;
    localparam int DEF_DEBOUNCE = 4;
    localparam int DEF_REPEAT_TICKS = 16;
endpackage

// File: rtl/keypad_scan_ctrl_divider.sv
// scan_divider: free-running 0..SCAN_DIV-1 counter; tick marks the last count of each column dwell.
module scan_divider
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = DEF_SCAN_DIV
) (
    input  logic clk,
    input  logic clear,
    output logic tick
);
    localparam int W = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
    logic [W-1:0] cnt;
    assign tick = cnt == W'(SCAN_DIV - 1);
    always_ff @(posedge clk or posedge clear)
        if (clear) cnt <= '0;
        else cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: column scan, debounce and encode of one keypad key with valid/ready handoff.
// Defining KEYPAD_REPEAT_EN re-presents a held key every REPEAT_TICKS ticks.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int NUM_COLS = DEF_NUM_COLS,
    parameter int NUM_ROWS = DEF_NUM_ROWS,
    parameter int SCAN_DIV = DEF_SCAN_DIV,
`ifdef KEYPAD_REPEAT_EN
    parameter int DEBOUNCE = DEF_DEBOUNCE,
    parameter int REPEAT_TICKS = DEF_REPEAT_TICKS
`else
    parameter int DEBOUNCE = DEF_DEBOUNCE
`endif
) (
    input  logic                clk,
    input  logic                clear,
    input  logic [NUM_ROWS-1:0] row_in,
    output logic [NUM_COLS-1:0] col_out,
    output logic [3:0]          key_code,
    output logic                key_valid,
    input  logic                key_ready,
    output logic                key_held
);
    localparam int CW = NUM_COLS > 1 ? $clog2(NUM_COLS) : 1;
    localparam int RW = NUM_ROWS > 1 ? $clog2(NUM_ROWS) : 1;
    localparam int DW = $clog2(DEBOUNCE + 1);
    state_t state, state_nxt;
    logic [CW-1:0] col, col_nxt, col_adv;
    logic [RW-1:0] row, row_nxt, low_row;
    logic [DW-1:0] deb, deb_nxt, deb_inc;
    logic [3:0] code_nxt;
    logic tick, hit, done;
`ifdef KEYPAD_REPEAT_EN
    localparam int RPW = $clog2(REPEAT_TICKS + 1);
    logic [RPW-1:0] rep, rep_nxt;
`endif

    scan_divider #(.SCAN_DIV(SCAN_DIV)) u_div (.clk(clk), .clear(clear), .tick(tick));

    assign col_adv = col == CW'(NUM_COLS - 1) ? '0 : col + 1'b1;
    assign deb_inc = deb == DW'(DEBOUNCE) ? deb : deb + 1'b1;
    assign done = deb_inc == DW'(DEBOUNCE);
    assign hit = row_in[row];

    // descending walk so the lowest asserted row wins
    always_comb begin
        low_row = '0;
        for (int i = NUM_ROWS - 1; i >= 0; i--)
            if (row_in[i]) low_row = RW'(i);
    end

    always_ff @(posedge clk or posedge clear)
        if (clear) state <= SCAN;
        else state <= state_nxt;

    always_comb begin
        state_nxt = state;
        col_nxt = col;
        row_nxt = row;
        deb_nxt = deb;
        code_nxt = key_code;
`ifdef KEYPAD_REPEAT_EN
        rep_nxt = rep;
`endif
        case (state)
            SCAN: if (tick) begin
                if (|row_in) begin
                    row_nxt = low_row;
                    deb_nxt = DW'(1);
                    state_nxt = keypad_pkg::DEBOUNCE;
                end else col_nxt = col_adv;
            end
            keypad_pkg::DEBOUNCE: if (tick) begin
                if (!hit) begin
                    deb_nxt = '0;
                    col_nxt = col_adv;
                    state_nxt = SCAN;
                end else begin
                    deb_nxt = deb_inc;
                    if (done) begin
                        code_nxt = 4'(int'(row) * NUM_COLS + int'(col));
                        state_nxt = PRESENT;
                    end
                end
            end
            PRESENT: if (key_ready) begin
                deb_nxt = '0;
`ifdef KEYPAD_REPEAT_EN
                rep_nxt = '0;
`endif
                state_nxt = RELEASE;
            end
            RELEASE: if (tick) begin
                deb_nxt = hit ? '0 : deb_inc;
                if (!hit && done) begin
                    deb_nxt = '0;
                    col_nxt = '0;
                    state_nxt = SCAN;
                end
`ifdef KEYPAD_REPEAT_EN
                rep_nxt = hit ? rep + 1'b1 : rep;
                if (hit && rep_nxt == RPW'(REPEAT_TICKS)) state_nxt = PRESENT;
`endif
            end
        endcase
    end

    always_ff @(posedge clk or posedge clear)
        if (clear) begin
            col <= '0;
            row <= '0;
            deb <= '0;
            key_code <= '0;
`ifdef KEYPAD_REPEAT_EN
            rep <= '0;
`endif
        end else begin
            col <= col_nxt;
            row <= row_nxt;
            deb <= deb_nxt;
            key_code <= code_nxt;
`ifdef KEYPAD_REPEAT_EN
            rep <= rep_nxt;
`endif
        end

    always_comb begin
        col_out = NUM_COLS'(1) << col;
        key_valid = state == PRESENT;
        key_held = state == RELEASE;
    end
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl: scoreboard bench for keypad_scan_ctrl at default parameters.
// Define KEYPAD_REPEAT_EN for both bench and design to exercise auto-repeat.
module tb_keypad_scan_ctrl;
    localparam int DIV = 7;
`ifdef KEYPAD_REPEAT_EN
    localparam int HS_AFTER_HOLD = 4;
`else
    localparam int HS_AFTER_HOLD = 3;
`endif
    logic clk, clear, key_valid, key_ready, key_held;
    logic [3:0] row_in, key_code;
    logic [2:0] col_out;
    int n_cmp = 0, n_bad = 0, nhs = 0, cyc = 0, det;
    int sb[$];

    keypad_scan_ctrl dut (
        .clk(clk), .clear(clear), .row_in(row_in), .col_out(col_out),
        .key_code(key_code), .key_valid(key_valid), .key_ready(key_ready), .key_held(key_held)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // cycle index since reset release; divider count equals cyc % DIV
    always @(posedge clk or posedge clear)
        if (clear) cyc <= 0;
        else cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int next_tick(input int n);
        return n + (DIV - 1 - n % DIV);
    endfunction

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic wait_col(input logic [2:0] c);
        int n = 0;
        while (col_out !== c && n < 40) begin @(negedge clk); n++; end
        check("col_wait", col_out, c);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!key_valid && n < 200) begin @(negedge clk); n++; end
        check("valid_wait", key_valid, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (key_held && n < 80) begin @(negedge clk); n++; end
        check("idle_wait", key_held, 0);
    endtask

    always @(negedge clk) begin
        #1;
        if (!clear && key_valid && key_ready) begin
            nhs++;
            check("sb_code", key_code, sb.size() != 0 ? sb.pop_front() : -1);
        end
    end

    initial begin
        clear = 1;
        row_in = 0;
        key_ready = 0;
        repeat (2) @(negedge clk);
        check("rst_col", col_out, 1);
        check("rst_valid", key_valid, 0);
        check("rst_code", key_code, 0);
        check("rst_held", key_held, 0);
        clear = 0;
        for (int i = 0; i < 50; i++) begin
            check("idle_col", col_out, 1 << ((cyc / DIV) % 3));
            @(negedge clk);
        end
        // clean press row1/col2
        key_ready = 1;
        wait_col(3'b100);
        row_in = 4'b0010;
        sb.push_back(5);
        det = next_tick(cyc);
        wait_valid();
        check("latency", cyc - det, 22);
        check("press_code", key_code, 5);
        @(negedge clk);
        check("pulse_valid", key_valid, 0);
        check("pulse_held", key_held, 1);
        row_in = 0;
        wait_idle();
        check("rel_col0", col_out, 1);
        check("hs_clean", nhs, 1);
        // bounce on col1: two matching ticks then release
        wait_col(3'b010);
        row_in = 4'b0001;
        det = next_tick(cyc);
        wait_cyc(det + 8);
        check("frozen_col", col_out, 3'b010);
        row_in = 0;
        wait_cyc(det + 15);
        check("bounce_col", col_out, 3'b100);
        check("bounce_valid", key_valid, 0);
        // backpressure with release before ready
        key_ready = 0;
        wait_col(3'b100);
        row_in = 4'b0010;
        sb.push_back(5);
        wait_valid();
        for (int i = 0; i < 40; i++) begin
            if (i == 20) row_in = 0;
            if (i % 8 == 0) begin
                check("bp_valid", key_valid, 1);
                check("bp_code", key_code, 5);
            end
            @(negedge clk);
        end
        check("bp_held", key_held, 0);
        key_ready = 1;
        @(negedge clk);
        check("bp_drop", key_valid, 0);
        wait_idle();
        check("hs_bp", nhs, 2);
        // rows 0 and 3 together on col1, then hold
        wait_col(3'b010);
        row_in = 4'b1001;
        sb.push_back(1);
        wait_valid();
        check("multi_code", key_code, 1);
        @(negedge clk);
`ifdef KEYPAD_REPEAT_EN
        sb.push_back(1);
`endif
        repeat (130) @(negedge clk);
        check("hold_held", key_held, 1);
        check("hold_hs", nhs, HS_AFTER_HOLD);
        row_in = 0;
        wait_idle();
        // clear mid-debounce discards the pending key
        key_ready = 0;
        wait_col(3'b100);
        row_in = 4'b0100;
        det = next_tick(cyc);
        wait_cyc(det + 8);
        clear = 1;
        row_in = 0;
        #1;
        check("clr_col", col_out, 1);
        check("clr_valid", key_valid, 0);
        check("clr_code", key_code, 0);
        check("clr_held", key_held, 0);
        @(negedge clk);
        clear = 0;
        repeat (3) @(negedge clk);
        check("clr_scan", col_out, 1);
        check("sb_drain", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
